// File: rtl/cpu_run_ctrl.sv
// Run/step controller: gates the CPU clock-enable from divider ticks or every
// cycle (fast). Supports free-run, single-step, halt, halt-instruction stop
// and a single PC breakpoint.
module cpu_run_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter bit          START_RUN = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick,
  input  logic              fast,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_halt,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_ce,
  output logic              running,
  output logic [1:0]        state,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  ce_count
);

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  localparam logic [1:0] C_BTN  = 2'd1;
  localparam logic [1:0] C_HREQ = 2'd2;
  localparam logic [1:0] C_BP   = 2'd3;

  localparam logic [1:0] S_RESET = START_RUN ? S_RUN : S_HALT;

  logic [1:0] state_q, state_d;
  logic       run_q, step_q, halt_q;
  logic       rise_run, rise_step, rise_halt;
  logic       slot, bp_hit, stop;
  logic       accept;
  logic       bp_arm_q, bp_arm_d;
  logic [1:0] cause_q, cause_d;
  logic       ce_q;
  logic [CNT_W-1:0] count_q;

  assign rise_run  = btn_run  & ~run_q;
  assign rise_step = btn_step & ~step_q;
  assign rise_halt = btn_halt & ~halt_q;
  assign slot      = fast | tick;
  assign bp_hit    = bp_en & bp_arm_q & (pc == bp_addr);
  assign stop      = rise_halt | halt_req | bp_hit;

  // Button edge history; loading current levels in reset avoids a false edge.
  always_ff @(posedge clk_in) begin
    run_q  <= btn_run;
    step_q <= btn_step;
    halt_q <= btn_halt;
  end

  // State register; running mirrors the registered state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= S_RESET;
      running <= (S_RESET == S_RUN);
    end else begin
      state_q <= state_d;
      running <= (state_d == S_RUN);
    end
  end

  // Next-state decode; an illegal encoding falls back to HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (rise_run)       state_d = S_RUN;
        else if (rise_step) state_d = S_STEP;
      end
      S_RUN: begin
        if (stop) state_d = S_HALT;
      end
      S_STEP: begin
        if (rise_halt || slot) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Slot acceptance, halt cause and breakpoint arming for the current state.
  always_comb begin
    accept   = 1'b0;
    cause_d  = cause_q;
    bp_arm_d = bp_arm_q;
    case (state_q)
      S_HALT: begin
        if (rise_run) bp_arm_d = 1'b0;
      end
      S_RUN: begin
        if (stop) begin
          if (rise_halt)     cause_d = C_BTN;
          else if (halt_req) cause_d = C_HREQ;
          else               cause_d = C_BP;
        end else if (slot) begin
          accept   = 1'b1;
          bp_arm_d = 1'b1;
        end
      end
      S_STEP: begin
        if (rise_halt)  cause_d = C_BTN;
        else if (slot)  accept  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered enable, issued-enable counter, cause and arm flag.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ce_q     <= 1'b0;
      count_q  <= '0;
      cause_q  <= 2'd0;
      bp_arm_q <= 1'b0;
    end else begin
      ce_q     <= accept;
      if (accept) count_q <= count_q + CNT_W'(1);
      cause_q  <= cause_d;
      bp_arm_q <= bp_arm_d;
    end
  end

  assign cpu_ce     = ce_q;
  assign ce_count   = count_q;
  assign halt_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a cycle-stamped enable scoreboard.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, fast = 1'b0;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_halt = 1'b0;
  logic        halt_req = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_reg = 32'd0;
  logic        pc_clr = 1'b0;
  logic        cpu_ce, running;
  logic [1:0]  state, halt_cause;
  logic [15:0] ce_count;

  logic        tick2 = 1'b0;
  logic        cpu_ce2, running2;
  logic [1:0]  state2, halt_cause2;
  logic [3:0]  ce_count2;
  logic [31:0] zero_addr = 32'd0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n2 = 0;
  logic [15:0] exp_cnt = 16'd0;
  int exp_q[$];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.ADDR_W(32), .CNT_W(16), .START_RUN(1'b0)) u_dut (
    .clk_in(clk), .rst(rst), .tick(tick), .fast(fast),
    .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .running(running), .state(state),
    .halt_cause(halt_cause), .ce_count(ce_count)
  );

  cpu_run_ctrl #(.ADDR_W(32), .CNT_W(4), .START_RUN(1'b1)) u_dut2 (
    .clk_in(clk), .rst(rst), .tick(tick2), .fast(1'b0),
    .btn_run(1'b0), .btn_step(1'b0), .btn_halt(1'b0),
    .halt_req(1'b0), .bp_en(1'b0), .bp_addr(zero_addr), .pc(zero_addr),
    .cpu_ce(cpu_ce2), .running(running2), .state(state2),
    .halt_cause(halt_cause2), .ce_count(ce_count2)
  );

  // CPU model: pc shows the advanced value while its enable is high.
  assign pc = pc_reg + (cpu_ce ? 32'd4 : 32'd0);
  always @(posedge clk) begin
    if (pc_clr)      pc_reg <= 32'd0;
    else if (cpu_ce) pc_reg <= pc_reg + 32'd4;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every enable must land on the next expected cycle stamp.
  always @(negedge clk) begin
    int e;
    if (cpu_ce2 === 1'b1) n2 = n2 + 1;
    if (cpu_ce === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL ce_unexpected cyc=%0d got=1 exp=0", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        assert (cyc === e) else begin
          failures++;
          $error("FAIL ce_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0] < cyc) begin
      e = exp_q.pop_front();
      checks++;
      assert (cpu_ce === 1'b1) else begin
        failures++;
        $error("FAIL ce_missing cyc=%0d exp_cycle=%0d", cyc, e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse(input bit expect_ce);
    tick = 1'b1;
    if (expect_ce) begin
      exp_q.push_back(cyc + 1);
      exp_cnt = exp_cnt + 16'd1;
    end
    step();
    tick = 1'b0;
  endtask

  initial begin
    // Reset, then sit in HALT while ticks arrive
    step(2);
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) tick_pulse(1'b0);
      else step();
    end
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_running", 32'(running), 32'd0);
    chk("halt_count", 32'(ce_count), 32'd0);
    chk("halt_cause0", 32'(halt_cause), 32'd0);

    // Free-run on slow ticks
    btn_run = 1'b1;
    step();
    chk("run_state", 32'(state), 32'd1);
    chk("run_running", 32'(running), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(499);
      tick_pulse(1'b1);
    end
    step(2);
    chk("run_count", 32'(ce_count), 32'(exp_cnt));

    // Halt button coincident with a tick drops that tick
    btn_halt = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("btnhalt_state", 32'(state), 32'd0);
    chk("btnhalt_cause", 32'(halt_cause), 32'd1);
    step(2);

    // Single step on a slow tick
    btn_halt = 1'b0; btn_run = 1'b0;
    step();
    btn_step = 1'b1;
    step();
    chk("step_state", 32'(state), 32'd2);
    step(200);
    tick_pulse(1'b1);
    chk("step_done", 32'(state), 32'd0);
    chk("step_count", 32'(ce_count), 32'(exp_cnt));
    chk("step_cause", 32'(halt_cause), 32'd1);

    // Single step in fast mode: enable two cycles after the edge
    btn_step = 1'b0;
    step();
    fast = 1'b1;
    btn_step = 1'b1;
    exp_q.push_back(cyc + 2);
    exp_cnt = exp_cnt + 16'd1;
    step(2);
    chk("fstep_state", 32'(state), 32'd0);
    fast = 1'b0;
    btn_step = 1'b0;
    step(2);
    chk("fstep_count", 32'(ce_count), 32'(exp_cnt));

    // Breakpoint at 0xC in fast RUN
    pc_clr = 1'b1;
    step();
    pc_clr = 1'b0;
    bp_en = 1'b1;
    bp_addr = 32'h0000000C;
    fast = 1'b1;
    btn_run = 1'b1;
    exp_q.push_back(cyc + 2);
    exp_q.push_back(cyc + 3);
    exp_q.push_back(cyc + 4);
    exp_cnt = exp_cnt + 16'd3;
    step(5);
    chk("bp_state", 32'(state), 32'd0);
    chk("bp_cause", 32'(halt_cause), 32'd3);
    chk("bp_pc", pc, 32'h0000000C);
    chk("bp_count", 32'(ce_count), 32'(exp_cnt));
    fast = 1'b0;
    btn_run = 1'b0;
    step(3);

    // Resume from the breakpoint makes progress without re-halting
    btn_run = 1'b1;
    step();
    chk("resume_state", 32'(state), 32'd1);
    tick_pulse(1'b1);
    step();
    chk("resume_run", 32'(state), 32'd1);
    chk("resume_pc", pc, 32'h00000010);
    btn_halt = 1'b1;
    step();
    chk("resume_halt", 32'(state), 32'd0);
    btn_halt = 1'b0; btn_run = 1'b0; bp_en = 1'b0;
    step();

    // Halt instruction in RUN, then stepping while it is still asserted
    btn_run = 1'b1;
    step();
    halt_req = 1'b1;
    step();
    chk("hreq_state", 32'(state), 32'd0);
    chk("hreq_cause", 32'(halt_cause), 32'd2);
    btn_run = 1'b0;
    btn_step = 1'b1;
    step(3);
    chk("hreq_step", 32'(state), 32'd2);
    tick_pulse(1'b1);
    chk("hreq_stepdone", 32'(state), 32'd0);
    chk("hreq_count", 32'(ce_count), 32'(exp_cnt));
    chk("hreq_cause2", 32'(halt_cause), 32'd2);
    btn_step = 1'b0; halt_req = 1'b0;
    step();

    // Simultaneous run+step edges: run wins; halt edge in HALT is inert
    btn_run = 1'b1; btn_step = 1'b1;
    step();
    chk("both_state", 32'(state), 32'd1);
    btn_halt = 1'b1;
    step();
    btn_run = 1'b0; btn_step = 1'b0; btn_halt = 1'b0;
    step();
    btn_halt = 1'b1;
    step();
    chk("halt_in_halt", 32'(state), 32'd0);
    btn_halt = 1'b0;

    // Reset aborts a pending step and suppresses the enable after it
    btn_step = 1'b1;
    step();
    chk("pre_rst_step", 32'(state), 32'd2);
    rst = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    rst = 1'b0;
    exp_cnt = 16'd0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(ce_count), 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    step();
    chk("rst_noce", 32'(cpu_ce), 32'd0);
    btn_step = 1'b0;

    // START_RUN instance, 4-bit counter wraps after 17 enables
    chk("sr_state", 32'(state2), 32'd1);
    chk("sr_running", 32'(running2), 32'd1);
    chk("sr_count", 32'(ce_count2), 32'd0);
    n2 = 0;
    for (int i = 0; i < 17; i++) begin
      tick2 = 1'b1;
      step();
      tick2 = 1'b0;
      step();
    end
    chk("wrap_count", 32'(ce_count2), 32'd1);
    chk("wrap_pulses", 32'(n2), 32'd17);
    chk("wrap_state", 32'(state2), 32'd1);
    chk("wrap_cause", 32'(halt_cause2), 32'd0);

    step(3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step controller that gates the CPU's clock-enable from the divider's slow tick pulse (one-cycle pulse per divide period) or from every cycle in fast mode. It provides free-run, single-step, halt, halt-instruction stop and a single PC breakpoint. It sits between the tick divider, the board buttons and switches, and the CPU core's clock-enable and PC.

Parameters:
ADDR_W, 32, width of pc and bp_addr
CNT_W, 16, width of the issued-enable counter
START_RUN, 0, 1 = leave reset in RUN instead of HALT

Ports:
clk_in  input  1  system clock; the block's only clock
rst  input  1  synchronous, active-high reset
tick  input  1  one-cycle pulse from the divider; the slow enable slot
fast  input  1  level; 1 = every cycle is an enable slot (tick ignored)
btn_run  input  1  level, debounced; its rising edge requests RUN
btn_step  input  1  level, debounced; its rising edge requests one step
btn_halt  input  1  level, debounced; its rising edge requests HALT
halt_req  input  1  level from CPU; a halt instruction is decoded
bp_en  input  1  breakpoint enable
bp_addr  input  ADDR_W  breakpoint PC
pc  input  ADDR_W  current CPU PC
cpu_ce  output  1  registered one-cycle clock-enable to the CPU
running  output  1  1 when state is RUN
state  output  2  0 = HALT, 1 = RUN, 2 = STEP
halt_cause  output  2  0 = reset or none, 1 = button, 2 = halt instruction, 3 = breakpoint
ce_count  output  CNT_W  count of issued cpu_ce pulses; wraps at 2^CNT_W

Behaviour:
- Reset: all registers update on posedge clk_in only.
- While rst=1: cpu_ce=0, ce_count=0, halt_cause=0, button edge registers load the current button levels (no false edge after reset), bp_arm=0.
- State after reset: HALT, or RUN if START_RUN=1; running follows state.
- Reset mid-step or mid-run aborts immediately; no cpu_ce is issued in the cycle after reset.
- Button edges: rise_x = btn_x & ~btn_x_q. Edge registers are updated every cycle.
- Enable slot: slot = fast | tick.
- cpu_ce is registered. A slot accepted in cycle N produces cpu_ce=1 in cycle N+1 only. Each accepted slot increments ce_count in the same cycle cpu_ce rises.
- HALT state:
  - rise_run: go to RUN, clear bp_arm.
  - else rise_step: go to STEP.
  - Otherwise stay in HALT; no slots are accepted.
  - halt_req is ignored in HALT, so a CPU sitting on a halt instruction can still be stepped or run.
- RUN state: stop = rise_halt | halt_req | (bp_en & bp_arm & pc==bp_addr).
  - If stop: go to HALT; a slot in the same cycle is NOT accepted. halt_cause uses priority button(1) > halt_req(2) > breakpoint(3).
  - Else if slot: accept the slot and set bp_arm=1.
  - bp_arm makes the first enable after entering RUN skip a breakpoint at the current PC, so resuming from a breakpoint makes progress.
  - rise_run and rise_step are ignored in RUN.
- STEP state:
  - rise_halt: go to HALT, halt_cause=1, no enable issued.
  - Else on the first slot: accept it and go to HALT; halt_cause is left unchanged.
  - halt_req and the breakpoint are ignored in STEP.
  - Waits indefinitely for a slot; in fast mode the step completes in the cycle after entry.
- Simultaneous edges in HALT: rise_run beats rise_step; rise_halt in HALT has no effect.
- Changing fast mid-RUN takes effect in the same cycle. At most one cpu_ce is issued per accepted slot, never two in consecutive cycles unless fast=1.
- ce_count wraps from 2^CNT_W-1 to 0 without flagging.
- An invalid state encoding (3) recovers to HALT on the next edge.

Test Plan:
1. Reset then halt: rst=1 for 2 cycles, then 0, START_RUN=0, tick every 500 cycles for 3000 cycles -> state=0, cpu_ce never 1, ce_count=0, halt_cause=0.
2. Run with ticks: btn_run 0->1, fast=0, tick at cycles 500/1000/1500 -> cpu_ce high exactly at cycles 501/1001/1501; ce_count=3.
3. Run and halt: btn_halt rise on the same cycle as a tick -> no cpu_ce for that tick; state=0 next cycle; halt_cause=1.
4. Single step: in HALT, btn_step rise then tick 200 cycles later -> exactly one cpu_ce, one cycle after the tick; state returns to 0; ce_count +1. With fast=1 instead, cpu_ce is 2 cycles after the rising edge.
5. Breakpoint: bp_en=1, bp_addr=0x0000000C, pc advances 0,4,8,C per cpu_ce in fast RUN -> halts with pc=0xC, halt_cause=3, ce_count=3. Then btn_run -> next cpu_ce is issued (pc moves to 0x10) and the block does not re-halt at 0xC.
6. Halt instruction and wrap: halt_req=1 in RUN -> HALT with halt_cause=2. With halt_req still 1, btn_step -> one cpu_ce. Separately, CNT_W=4 and 17 enables -> ce_count=1.
